// File: rtl/cpu_fsm_pkg.sv
// Shared types and constants for the load sequencer: state encoding and register indices.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cpu_fsm_pkg;

  localparam int IDX_W    = 6;
  localparam int NUM_REGS = 6;

  localparam int R0_IDX = 0;
  localparam int R1_IDX = 1;
  localparam int R2_IDX = 2;
  localparam int R3_IDX = 3;
  localparam int P0_IDX = 4;
  localparam int P1_IDX = 5;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_MEMRD = 3'd2,
    ST_WAIT1 = 3'd3,
    ST_XFER  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

endpackage

// File: rtl/reg_sel_dec.sv
// Register index decoder: 6-bit index to one-hot register select plus a valid flag.
// Latency: combinational, zero cycles.
// Backpressure: none; out-of-range indices give an all-zero select and valid=0.
module reg_sel_dec
  import cpu_fsm_pkg::*;
(
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] sel,
  output logic                valid
);

  // One select bit per architectural register; anything past P1 selects nothing.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = (idx == IDX_W'(i));
    end
    valid = |sel;
  end

endmodule

// File: rtl/load_fsm.sv
// Load sequencer: register[Ri] <= MEM[register[Rj]] via MAR/MDR bus control; optional WAIT1 timeout under LOAD_TIMEOUT_EN.
// Latency: done pulses 5 cycles after start when MFC arrives on the first WAIT1 cycle, +1 per extra WAIT1 cycle.
// Backpressure: start only accepted in INIT (ignored while busy); WAIT1 stalls until MFC (or timeout when enabled).
module load_fsm
  import cpu_fsm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             MFC,
  input  logic [IDX_W-1:0] Ri,
  input  logic [IDX_W-1:0] Rj,
  output logic             R0_read,
  output logic             R1_read,
  output logic             R2_read,
  output logic             R3_read,
  output logic             P0_read,
  output logic             P1_read,
  output logic             R0_write,
  output logic             R1_write,
  output logic             R2_write,
  output logic             R3_write,
  output logic             P0_write,
  output logic             P1_write,
  output logic             MAR_write,
  output logic             MAR_mem_read,
  output logic             MEM_RW,
  output logic             MEM_EN,
  output logic             MDR_mem_write,
  output logic             MDR_read,
  output logic             done,
  output logic             error
);

  state_t              state;
  logic [IDX_W-1:0]    ri_q;
  logic [IDX_W-1:0]    rj_q;
  logic [NUM_REGS-1:0] rd_sel_q;
  logic [NUM_REGS-1:0] wr_sel_q;
  logic                mar_write_q;
  logic                mar_mem_read_q;
  logic                mem_rw_q;
  logic                mem_en_q;
  logic                mdr_mem_write_q;
  logic                mdr_read_q;
  logic                done_q;
  logic                error_q;

  // In INIT the decoders look at the live inputs (the values being latched);
  // afterwards only the latched copies matter, so later input changes are inert.
  logic [IDX_W-1:0]    ri_idx;
  logic [IDX_W-1:0]    rj_idx;
  logic [NUM_REGS-1:0] ri_sel;
  logic [NUM_REGS-1:0] rj_sel;
  logic                ri_valid;
  logic                rj_valid;

  assign ri_idx = (state == ST_INIT) ? Ri : ri_q;
  assign rj_idx = (state == ST_INIT) ? Rj : rj_q;

  reg_sel_dec u_ri_dec (
    .idx   (ri_idx),
    .sel   (ri_sel),
    .valid (ri_valid)
  );

  reg_sel_dec u_rj_dec (
    .idx   (rj_idx),
    .sel   (rj_sel),
    .valid (rj_valid)
  );

`ifdef LOAD_TIMEOUT_EN
  logic [7:0] wait_cnt;
`else
  // Parameter is only meaningful with the timeout built in.
  logic unused_timeout;
  assign unused_timeout = |32'(TIMEOUT_CYCLES);
`endif

  // Sequencer: state plus registered Moore outputs, which are computed for the
  // state being entered so they line up with that state's cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_INIT;
      ri_q            <= '0;
      rj_q            <= '0;
      rd_sel_q        <= '0;
      wr_sel_q        <= '0;
      mar_write_q     <= 1'b0;
      mar_mem_read_q  <= 1'b0;
      mem_rw_q        <= 1'b0;
      mem_en_q        <= 1'b0;
      mdr_mem_write_q <= 1'b0;
      mdr_read_q      <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
      wait_cnt        <= '0;
`endif
    end else begin
      rd_sel_q        <= '0;
      wr_sel_q        <= '0;
      mar_write_q     <= 1'b0;
      mar_mem_read_q  <= 1'b0;
      mem_rw_q        <= 1'b0;
      mem_en_q        <= 1'b0;
      mdr_mem_write_q <= 1'b0;
      mdr_read_q      <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      case (state)
        ST_INIT: begin
          if (start) begin
            ri_q <= Ri;
            rj_q <= Rj;
            if (ri_valid && rj_valid) begin
              state       <= ST_ADDR;
              rd_sel_q    <= rj_sel;
              mar_write_q <= 1'b1;
            end else begin
              state   <= ST_ERR;
              error_q <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          state          <= ST_MEMRD;
          mar_mem_read_q <= 1'b1;
          mem_rw_q       <= 1'b1;
          mem_en_q       <= 1'b1;
        end
        ST_MEMRD: begin
          state           <= ST_WAIT1;
          mar_mem_read_q  <= 1'b1;
          mem_rw_q        <= 1'b1;
          mem_en_q        <= 1'b1;
          mdr_mem_write_q <= 1'b1;
`ifdef LOAD_TIMEOUT_EN
          wait_cnt        <= '0;
`endif
        end
        ST_WAIT1: begin
          if (MFC) begin
            state      <= ST_XFER;
            mdr_read_q <= 1'b1;
            wr_sel_q   <= ri_sel;
`ifdef LOAD_TIMEOUT_EN
          end else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            state   <= ST_ERR;
            error_q <= 1'b1;
`endif
          end else begin
            mar_mem_read_q  <= 1'b1;
            mem_rw_q        <= 1'b1;
            mem_en_q        <= 1'b1;
            mdr_mem_write_q <= 1'b1;
`ifdef LOAD_TIMEOUT_EN
            wait_cnt        <= wait_cnt + 8'd1;
`endif
          end
        end
        ST_XFER: begin
          state  <= ST_DONE;
          done_q <= 1'b1;
        end
        ST_DONE: state <= ST_INIT;
        ST_ERR:  state <= ST_INIT;
        default: state <= ST_INIT;
      endcase
    end
  end

  assign R0_read       = rd_sel_q[R0_IDX];
  assign R1_read       = rd_sel_q[R1_IDX];
  assign R2_read       = rd_sel_q[R2_IDX];
  assign R3_read       = rd_sel_q[R3_IDX];
  assign P0_read       = rd_sel_q[P0_IDX];
  assign P1_read       = rd_sel_q[P1_IDX];
  assign R0_write      = wr_sel_q[R0_IDX];
  assign R1_write      = wr_sel_q[R1_IDX];
  assign R2_write      = wr_sel_q[R2_IDX];
  assign R3_write      = wr_sel_q[R3_IDX];
  assign P0_write      = wr_sel_q[P0_IDX];
  assign P1_write      = wr_sel_q[P1_IDX];
  assign MAR_write     = mar_write_q;
  assign MAR_mem_read  = mar_mem_read_q;
  assign MEM_RW        = mem_rw_q;
  assign MEM_EN        = mem_en_q;
  assign MDR_mem_write = mdr_mem_write_q;
  assign MDR_read      = mdr_read_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_load_fsm.sv
// Testbench for load_fsm: table of load requests, randomized loads with input noise, reset/timeout/back-to-back sequences.
// Latency: n/a.
// Backpressure: n/a; honours LOAD_TIMEOUT_EN the same way the design does.
module tb_load_fsm;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       MFC = 1'b0;
  logic [5:0] Ri = '0;
  logic [5:0] Rj = '0;
  logic R0_read, R1_read, R2_read, R3_read, P0_read, P1_read;
  logic R0_write, R1_write, R2_write, R3_write, P0_write, P1_write;
  logic MAR_write, MAR_mem_read, MEM_RW, MEM_EN, MDR_mem_write, MDR_read, done, error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_fsm #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .MFC(MFC), .Ri(Ri), .Rj(Rj),
    .R0_read(R0_read), .R1_read(R1_read), .R2_read(R2_read), .R3_read(R3_read),
    .P0_read(P0_read), .P1_read(P1_read),
    .R0_write(R0_write), .R1_write(R1_write), .R2_write(R2_write), .R3_write(R3_write),
    .P0_write(P0_write), .P1_write(P1_write),
    .MAR_write(MAR_write), .MAR_mem_read(MAR_mem_read), .MEM_RW(MEM_RW), .MEM_EN(MEM_EN),
    .MDR_mem_write(MDR_mem_write), .MDR_read(MDR_read), .done(done), .error(error)
  );

  // Output word: [19:14] reads (bit = register index), [13:8] writes,
  // [7] MAR_write [6] MAR_mem_read [5] MEM_RW [4] MEM_EN [3] MDR_mem_write
  // [2] MDR_read [1] done [0] error
  localparam logic [19:0] W_IDLE  = 20'h00000;
  localparam logic [19:0] W_MEMRD = 20'h00070;
  localparam logic [19:0] W_WAIT  = 20'h00078;
  localparam logic [19:0] W_DONE  = 20'h00002;
  localparam logic [19:0] W_ERR   = 20'h00001;

  function automatic logic [19:0] out_word();
    out_word = {P1_read, P0_read, R3_read, R2_read, R1_read, R0_read,
                P1_write, P0_write, R3_write, R2_write, R1_write, R0_write,
                MAR_write, MAR_mem_read, MEM_RW, MEM_EN, MDR_mem_write, MDR_read,
                done, error};
  endfunction

  function automatic logic [19:0] w_addr(input int rj);
    w_addr = 20'h00080;
    w_addr[14 + rj] = 1'b1;
  endfunction

  function automatic logic [19:0] w_xfer(input int ri);
    w_xfer = 20'h00004;
    w_xfer[8 + ri] = 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One load: the expected per-cycle output trace is laid out from the rules
  // (ADDR, MEMRD, w WAIT1 cycles, XFER, DONE, back to idle), MFC is raised on
  // the w-th WAIT1 cycle, and latency counts cycles from the start cycle to the
  // first done/error pulse. With noise, start/Ri/Rj wiggle and MFC toggles
  // outside WAIT1, none of which may change the trace.
  task automatic run_txn(input int ri, input int rj, input int w, input bit noise,
                         output int lat, output bit got_err);
    logic [19:0] tr[$];
    bit          timed_out;
    tr = {};
    timed_out = 1'b0;
    if (ri > 5 || rj > 5) begin
      tr.push_back(W_ERR);
    end else begin
      tr.push_back(w_addr(rj));
      tr.push_back(W_MEMRD);
      for (int i = 1; i <= w; i++) begin
        tr.push_back(W_WAIT);
`ifdef LOAD_TIMEOUT_EN
        if (i == TMO && i < w) begin
          timed_out = 1'b1;
          break;
        end
`endif
      end
      if (timed_out) tr.push_back(W_ERR);
      else begin
        tr.push_back(w_xfer(ri));
        tr.push_back(W_DONE);
      end
    end
    tr.push_back(W_IDLE);

    lat = -1;
    got_err = 1'b0;
    Ri = 6'(ri);
    Rj = 6'(rj);
    start = 1'b1;
    MFC = noise ? 1'($urandom) : 1'b0;
    for (int k = 0; k < tr.size(); k++) begin
      @(posedge clk); #1;
      check("trace", 32'(out_word()), 32'(tr[k]));
      if (lat < 0 && (done || error)) begin
        lat = k + 1;
        got_err = error;
      end
      start = (noise && k != tr.size() - 1) ? 1'($urandom) : 1'b0;
      Ri    = noise ? 6'($urandom) : 6'(ri);
      Rj    = noise ? 6'($urandom) : 6'(rj);
      if (k == 1 + w && tr[k] == W_WAIT) MFC = 1'b1;
      else if (tr[k] == W_WAIT)          MFC = 1'b0;
      else                               MFC = noise ? 1'($urandom) : 1'b0;
    end
    start = 1'b0;
    MFC = 1'b0;
  endtask

  typedef struct {
    int ri;
    int rj;
    int w;
    int exp_lat;
    bit exp_err;
  } vec_t;

  initial begin
    vec_t tbl[9];
    int   lat;
    bit   gerr;
    int   dq[$];
    int   exp_dq[4];

    tbl[0] = '{2, 4, 3, 7, 1'b0};    // P0 address -> R2, three WAIT1 cycles
    tbl[1] = '{0, 0, 1, 5, 1'b0};    // Ri = Rj, minimum latency
    tbl[2] = '{5, 5, 2, 6, 1'b0};
    tbl[3] = '{3, 1, 1, 5, 1'b0};
    tbl[4] = '{4, 5, 5, 9, 1'b0};
    tbl[5] = '{7, 0, 1, 1, 1'b1};    // bad Ri
    tbl[6] = '{0, 6, 1, 1, 1'b1};    // bad Rj
    tbl[7] = '{63, 63, 1, 1, 1'b1};
    tbl[8] = '{1, 2, TMO, 4 + TMO, 1'b0}; // MFC on the last allowed WAIT1 cycle

    // Reset state
    #1;
    check("reset_outputs", 32'(out_word()), 32'(W_IDLE));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", 32'(out_word()), 32'(W_IDLE));

    // Table of directed loads
    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].ri, tbl[i].rj, tbl[i].w, 1'b0, lat, gerr);
      check("tbl_latency", 32'(lat), 32'(tbl[i].exp_lat));
      check("tbl_err", 32'(gerr), 32'(tbl[i].exp_err));
    end

    // Long MFC stall: timeout aborts, otherwise the load just waits
    run_txn(0, 5, 100, 1'b0, lat, gerr);
`ifdef LOAD_TIMEOUT_EN
    check("stall_latency", 32'(lat), 32'(3 + TMO));
    check("stall_err", 32'(gerr), 32'(1));
`else
    check("stall_latency", 32'(lat), 32'(104));
    check("stall_err", 32'(gerr), 32'(0));
`endif

    // Reset asserted in WAIT1 clears outputs without waiting for a clock
    Ri = 6'd1; Rj = 6'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("in_wait1", 32'(out_word()), 32'(W_WAIT));
    #2 reset = 1'b0;
    #1;
    check("reset_async", 32'(out_word()), 32'(W_IDLE));
    MFC = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 32'(out_word()), 32'(W_IDLE));
    reset = 1'b1;
    MFC = 1'b0;
    @(posedge clk); #1;
    check("no_resume", 32'(out_word()), 32'(W_IDLE));
    run_txn(1, 1, 2, 1'b0, lat, gerr);
    check("post_reset_lat", 32'(lat), 32'(6));

    // start held high with MFC=1: back-to-back loads, one every 6 cycles
    exp_dq = '{5, 11, 17, 23};
    Ri = 6'd0; Rj = 6'd3; MFC = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      start = (c <= 20);
      @(posedge clk); #1;
      if (done) dq.push_back(c);
    end
    start = 1'b0; MFC = 1'b0;
    check("b2b_count", 32'(dq.size()), 32'(4));
    for (int i = 0; i < 4; i++) begin
      check("b2b_done_cycle", (i < dq.size()) ? 32'(dq[i]) : 32'hFFFF_FFFF, 32'(exp_dq[i]));
    end

    // Randomized loads with input noise
    for (int n = 0; n < 40; n++) begin
      int ri_r, rj_r, w_r;
      ri_r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 63)) : int'($urandom_range(0, 5));
      rj_r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 63)) : int'($urandom_range(0, 5));
      w_r  = $urandom_range(1, 6);
      run_txn(ri_r, rj_r, w_r, 1'b1, lat, gerr);
      check("rand_latency", 32'(lat), (ri_r > 5 || rj_r > 5) ? 32'(1) : 32'(4 + w_r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
